// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I shared datapath.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes halt with trap=1 instead of retiring as NOP.
module rv32i_mc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic [31:0] pc_rst_val,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    state_t     state;
    logic [6:0] opc;
    logic       unused_instr_bits;
    logic       is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_auipc, is_lui;
    logic       is_exec_cls, is_nop_cls;

    assign opc               = instr[6:0];
    assign unused_instr_bits = ^instr[31:7];
    assign is_r     = (opc == OP_R);
    assign is_i     = (opc == OP_I);
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);
    assign is_br    = (opc == OP_BR);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR);
    assign is_auipc = (opc == OP_AUIPC);
    assign is_lui   = (opc == OP_LUI);
    assign is_exec_cls = is_r | is_i | is_load | is_store | is_br | is_jal |
                         is_jalr | is_auipc | is_lui;
    assign is_nop_cls  = (opc == OP_FENCE) || (opc == OP_SYS);

    assign pc_rst_val = RESET_PC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= 32'd0;
        end else begin
            if (retire) instret <= instret + 32'd1;
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (is_exec_cls)     state <= S_EXEC;
                    else if (is_nop_cls) state <= S_FETCH;
                    else begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_HALT;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) state <= S_MEM;
                    else if (is_br)          state <= S_FETCH;
                    else                     state <= S_WB;
                end
                S_MEM:    if (mem_ready) state <= is_load ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Reset gates every output combinationally so nothing leaks before the reset edge lands.
    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        trap         = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    retire = is_nop_cls;
`else
                    retire = !is_exec_cls;
`endif
                end
                S_EXEC: begin
                    if (is_r) begin
                        alu_op = 2'd1;
                    end else if (is_i) begin
                        alu_b_sel = 1'b1;
                        alu_op    = 2'd1;
                    end else if (is_load || is_store) begin
                        alu_b_sel = 1'b1;
                    end else if (is_br) begin
                        // Target comes from the dedicated PC+imm adder; the ALU compares rs1/rs2.
                        alu_op = 2'd2;
                        pc_we  = br_taken;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end else if (is_jal || is_auipc) begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_we     = is_jal;
                        pc_sel    = is_jal ? 2'd1 : 2'd0;
                    end else if (is_jalr) begin
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 2'd2;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    retire       = mem_ready && is_store;
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                    if (is_load)                wb_sel = 2'd1;
                    else if (is_jal || is_jalr) wb_sel = 2'd2;
                    else if (is_lui)            wb_sel = 2'd3;
                end
                S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    trap = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
